// File: rtl/clock_time_core.sv
// clock_time_core: 24-hour BCD time-keeping core with a button-driven set mode.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous reset, active-low
//   sec_in    in   1 Hz level, synchronous to clk; its rising edge advances one second
//   btn_mode  in   raw mode button (active-high, bouncy): RUN -> SET_HOUR -> SET_MIN -> RUN
//   btn_up    in   raw increment button (active-high, bouncy), used in the set states
//   digit1..6 out  BCD digits: sec ones/tens, min ones/tens, hour ones/tens (registered)
//   set_mode  out  2'b00 RUN, 2'b01 SET_HOUR, 2'b10 SET_MIN
//   blank     out  (CLOCK_BLINK_EN only) per-digit blank, bit i blanks digit(i+1)
//
// Optional feature macro: CLOCK_BLINK_EN adds the blank output and the blink flag that
// flashes the field being edited.

module clock_time_core #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic [3:0] digit6,
`ifdef CLOCK_BLINK_EN
    output logic [5:0] blank,
`endif
    output logic [1:0] set_mode
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10
    } state_e;

    localparam logic [DB_W-1:0] DbLast = DB_W'(DEBOUNCE_CYCLES - 1);

    // Hours 00..23 in BCD, wrapping 23 -> 00.
    function automatic logic [7:0] inc_hours(input logic [7:0] h);
        if (h == 8'h23)             return 8'h00;
        else if (h[3:0] == 4'd9)    return {h[7:4] + 4'd1, 4'd0};
        else                        return {h[7:4], h[3:0] + 4'd1};
    endfunction

    // Minutes 00..59 in BCD, wrapping 59 -> 00.
    function automatic logic [7:0] inc_min(input logic [7:0] m);
        if (m == 8'h59)             return 8'h00;
        else if (m[3:0] == 4'd9)    return {m[7:4] + 4'd1, 4'd0};
        else                        return {m[7:4], m[3:0] + 4'd1};
    endfunction

    state_e               state_q, state_d;
    logic                 sec_q;
    logic                 tick;
    logic [3:0]           s0_q, s1_q, m0_q, m1_q, h0_q, h1_q;
    logic [3:0]           s0_d, s1_d, m0_d, m1_d, h0_d, h1_d;

    // Debounce state; index 0 is the mode button, index 1 the up button.
    logic [1:0]           btn_raw;
    logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]           db_lvl_q, db_lvl_d, db_prev_q;
    logic [1:0]           press;
    logic                 mode_press, up_press;

    assign btn_raw    = {btn_up, btn_mode};
    assign press      = db_lvl_q & ~db_prev_q;
    assign mode_press = press[0];
    assign up_press   = press[1];
    assign tick       = sec_in & ~sec_q;

    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        for (int i = 0; i < 2; i++) begin
            if (btn_raw[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_lvl_d[i] = btn_raw[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        m0_d    = m0_q;
        m1_d    = m1_q;
        h0_d    = h0_q;
        h1_d    = h1_q;
        case (state_q)
            StRun: begin
                if (tick) begin
                    if (s0_q != 4'd9) begin
                        s0_d = s0_q + 4'd1;
                    end else begin
                        s0_d = 4'd0;
                        if (s1_q != 4'd5) begin
                            s1_d = s1_q + 4'd1;
                        end else begin
                            s1_d = 4'd0;
                            {m1_d, m0_d} = inc_min({m1_q, m0_q});
                            if ({m1_q, m0_q} == 8'h59) begin
                                {h1_d, h0_d} = inc_hours({h1_q, h0_q});
                            end
                        end
                    end
                end
                if (mode_press) state_d = StSetHour;
            end
            StSetHour: begin
                if (up_press)   {h1_d, h0_d} = inc_hours({h1_q, h0_q});
                if (mode_press) state_d = StSetMin;
            end
            StSetMin: begin
                if (up_press) {m1_d, m0_d} = inc_min({m1_q, m0_q});
                if (mode_press) begin
                    state_d = StRun;
                    s0_d    = 4'd0;
                    s1_d    = 4'd0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            sec_q     <= 1'b0;
            db_cnt_q  <= '0;
            db_lvl_q  <= '0;
            db_prev_q <= '0;
            s0_q      <= 4'd0;
            s1_q      <= 4'd0;
            m0_q      <= 4'd0;
            m1_q      <= 4'd0;
            h0_q      <= 4'd0;
            h1_q      <= 4'd0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_in;
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            m0_q      <= m0_d;
            m1_q      <= m1_d;
            h0_q      <= h0_d;
            h1_q      <= h1_d;
        end
    end

`ifdef CLOCK_BLINK_EN
    logic blink_q, blink_d;

    // Toggle on both sec_in edges; an up press shows the edited field at once.
    always_comb begin
        blink_d = blink_q;
        if (sec_in != sec_q) blink_d = ~blink_q;
        if (up_press)        blink_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blink_q <= 1'b0;
        else      blink_q <= blink_d;
    end

    always_comb begin
        blank = '0;
        case (state_q)
            StSetHour: blank[5:4] = {2{blink_q}};
            StSetMin:  blank[3:2] = {2{blink_q}};
            default:   blank      = '0;
        endcase
    end
`endif

    assign digit1   = s0_q;
    assign digit2   = s1_q;
    assign digit3   = m0_q;
    assign digit4   = m1_q;
    assign digit5   = h0_q;
    assign digit6   = h1_q;
    assign set_mode = state_q;

endmodule

// File: tb/tb_clock_time_core.sv
module tb_clock_time_core;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       sec_in;
    logic       btn_mode;
    logic       btn_up;
    logic [3:0] digit1, digit2, digit3, digit4, digit5, digit6;
    logic [1:0] set_mode;
`ifdef CLOCK_BLINK_EN
    logic [5:0] blank;
`endif
    logic [23:0] t;

    int total = 0;
    int bad   = 0;

    clock_time_core #(
        .DEBOUNCE_CYCLES(D),
        .DB_W           (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sec_in  (sec_in),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .digit1  (digit1),
        .digit2  (digit2),
        .digit3  (digit3),
        .digit4  (digit4),
        .digit5  (digit5),
        .digit6  (digit6),
`ifdef CLOCK_BLINK_EN
        .blank   (blank),
`endif
        .set_mode(set_mode)
    );

    assign t = {digit6, digit5, digit4, digit3, digit2, digit1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        sec_in = 1'b1;
        cyc(1);
        sec_in = 1'b0;
        cyc(1);
    endtask

    task automatic press(input logic m, input logic u);
        btn_mode = m;
        btn_up   = u;
        cyc(D + 2);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        cyc(D + 2);
    endtask

    task automatic test_reset();
        rst = 1'b1; sec_in = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
        #1 rst = 1'b0;
        #2;
        total++;
        if (t !== 24'h000000) begin bad++; $display("FAIL reset_time got=%h want=000000", t); end
        total++;
        if (set_mode !== 2'b00) begin bad++; $display("FAIL reset_mode got=%b want=00", set_mode); end
        cyc(2);
        rst = 1'b1;
        cyc(1);
        repeat (3) do_tick();
        total++;
        if (t !== 24'h000003) begin bad++; $display("FAIL three_ticks got=%h want=000003", t); end
        // Reset asserted mid-cycle while a debounce count is in progress.
        btn_up = 1'b1;
        do_tick();
        do_tick();
        #2 rst = 1'b0;
        #1;
        total++;
        if (t !== 24'h000000) begin bad++; $display("FAIL async_reset got=%h want=000000", t); end
        btn_up = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        repeat (3) do_tick();
        total++;
        if (t !== 24'h000003) begin bad++; $display("FAIL after_reset got=%h want=000003", t); end
    endtask

    task automatic test_carry();
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b01) begin bad++; $display("FAIL to_set_hour got=%b want=01", set_mode); end
        repeat (23) press(1'b0, 1'b1);
        total++;
        if (t !== 24'h230003) begin bad++; $display("FAIL load_hours got=%h want=230003", t); end
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b10) begin bad++; $display("FAIL to_set_min got=%b want=10", set_mode); end
        repeat (59) press(1'b0, 1'b1);
        total++;
        if (t !== 24'h235903) begin bad++; $display("FAIL load_min got=%h want=235903", t); end
        press(1'b1, 1'b0);
        total++;
        if (t !== 24'h235900 || set_mode !== 2'b00) begin
            bad++; $display("FAIL exit_clears_sec got=%h/%b want=235900/00", t, set_mode);
        end
        repeat (59) do_tick();
        total++;
        if (t !== 24'h235959) begin bad++; $display("FAIL tick59 got=%h want=235959", t); end
        do_tick();
        total++;
        if (t !== 24'h000000) begin bad++; $display("FAIL midnight got=%h want=000000", t); end
    endtask

    task automatic test_bounce();
        press(1'b1, 1'b0);
        repeat (23) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (7) press(1'b0, 1'b1);
        total++;
        if (t !== 24'h230700) begin bad++; $display("FAIL bounce_setup got=%h want=230700", t); end
        repeat (3) begin
            btn_up = 1'b1;
            cyc(2);
            btn_up = 1'b0;
            cyc(2);
        end
        btn_up = 1'b1;
        cyc(D);
        total++;
        if (t !== 24'h230700) begin bad++; $display("FAIL bounce_early got=%h want=230700", t); end
        cyc(1);
        total++;
        if (t !== 24'h230800) begin bad++; $display("FAIL bounce_latency got=%h want=230800", t); end
        cyc(10 - (D + 1));
        btn_up = 1'b0;
        cyc(D + 2);
        total++;
        if (t !== 24'h230800) begin bad++; $display("FAIL bounce_once got=%h want=230800", t); end
    endtask

    task automatic test_wrap_frozen();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b01) begin bad++; $display("FAIL reenter_hour got=%b want=01", set_mode); end
        repeat (5) do_tick();
        total++;
        if (t !== 24'h230800) begin bad++; $display("FAIL frozen got=%h want=230800", t); end
        press(1'b0, 1'b1);
        total++;
        if (t !== 24'h000800) begin bad++; $display("FAIL hour_wrap got=%h want=000800", t); end
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (51) press(1'b0, 1'b1);
        total++;
        if (t !== 24'h015900) begin bad++; $display("FAIL min_load got=%h want=015900", t); end
        press(1'b0, 1'b1);
        total++;
        if (t !== 24'h010000) begin bad++; $display("FAIL min_wrap got=%h want=010000", t); end
        press(1'b1, 1'b0);
    endtask

    task automatic test_simultaneous();
        repeat (9) do_tick();
        total++;
        if (t !== 24'h010009) begin bad++; $display("FAIL pre_sim got=%h want=010009", t); end
        btn_mode = 1'b1;
        cyc(D);
        sec_in = 1'b1;
        cyc(1);
        total++;
        if (t !== 24'h010010 || set_mode !== 2'b01) begin
            bad++; $display("FAIL tick_and_mode got=%h/%b want=010010/01", t, set_mode);
        end
        sec_in   = 1'b0;
        btn_mode = 1'b0;
        cyc(D + 2);
        press(1'b1, 1'b1);
        total++;
        if (t !== 24'h020010 || set_mode !== 2'b10) begin
            bad++; $display("FAIL up_and_mode got=%h/%b want=020010/10", t, set_mode);
        end
    endtask

    task automatic test_set_min_exit();
        press(1'b0, 1'b1);
        total++;
        if (t !== 24'h020110) begin bad++; $display("FAIL min_inc got=%h want=020110", t); end
`ifdef CLOCK_BLINK_EN
        total++;
        if (blank !== 6'b000000) begin bad++; $display("FAIL blank_forced got=%b want=000000", blank); end
`endif
        sec_in = 1'b1;
        cyc(1);
`ifdef CLOCK_BLINK_EN
        total++;
        if (blank !== 6'b001100) begin bad++; $display("FAIL blank_rise got=%b want=001100", blank); end
`endif
        sec_in = 1'b0;
        cyc(1);
`ifdef CLOCK_BLINK_EN
        total++;
        if (blank !== 6'b000000) begin bad++; $display("FAIL blank_fall got=%b want=000000", blank); end
`endif
        sec_in = 1'b1;
        cyc(1);
`ifdef CLOCK_BLINK_EN
        total++;
        if (blank !== 6'b001100) begin bad++; $display("FAIL blank_rise2 got=%b want=001100", blank); end
`endif
        sec_in = 1'b0;
        cyc(1);
        total++;
        if (t !== 24'h020110) begin bad++; $display("FAIL min_frozen got=%h want=020110", t); end
        press(1'b1, 1'b0);
        total++;
        if (t !== 24'h020100 || set_mode !== 2'b00) begin
            bad++; $display("FAIL min_exit got=%h/%b want=020100/00", t, set_mode);
        end
    endtask

    task automatic test_run_up_ignored();
        press(1'b0, 1'b1);
        total++;
        if (t !== 24'h020100) begin bad++; $display("FAIL run_up got=%h want=020100", t); end
        sec_in = 1'b1;
        cyc(1);
        total++;
        if (t !== 24'h020101) begin bad++; $display("FAIL run_tick got=%h want=020101", t); end
`ifdef CLOCK_BLINK_EN
        total++;
        if (blank !== 6'b000000) begin bad++; $display("FAIL blank_run got=%b want=000000", blank); end
`endif
        sec_in = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_set();
        press(1'b1, 1'b0);
        total++;
        if (set_mode !== 2'b01) begin bad++; $display("FAIL mid_set_enter got=%b want=01", set_mode); end
        #2 rst = 1'b0;
        #1;
        total++;
        if (t !== 24'h000000 || set_mode !== 2'b00) begin
            bad++; $display("FAIL mid_set_reset got=%h/%b want=000000/00", t, set_mode);
        end
        cyc(2);
        rst = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_carry();
        test_bounce();
        test_wrap_frozen();
        test_simultaneous();
        test_set_min_exit();
        test_run_up_ignored();
        test_reset_mid_set();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_time_core.md
Name: clock_time_core

Overview:
- Time-keeping core for the digital clock. Upstream of the six seg7 decoders; replaces the free-running per-digit counters.
- Consumes the 1 Hz divider output and two raw push-buttons.
- Keeps 24-hour BCD time with a button-driven set mode and drives digit1..digit6 (BCD, 4 bits each) straight into the decoders.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive clk cycles a button must hold a new level before it is accepted (10 ms at 50 MHz).
- DB_W, 20, width of the debounce counters; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous reset, active-low.
- sec_in  input  1  1 Hz level from the clock divider, synchronous to clk; its rising edge is one second.
- btn_mode  input  1  raw mode button, active-high, bouncy.
- btn_up  input  1  raw increment button, active-high, bouncy.
- digit1  output  4  seconds ones (BCD).
- digit2  output  4  seconds tens (BCD).
- digit3  output  4  minutes ones (BCD).
- digit4  output  4  minutes tens (BCD).
- digit5  output  4  hours ones (BCD).
- digit6  output  4  hours tens (BCD).
- set_mode  output  2  current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN.

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous, active-low. On reset:
  - all digits = 0 (00:00:00);
  - set_mode = 00;
  - debounce counters = 0, debounced levels = 0;
  - sec_in edge register = 0.
- Reset mid-set: returns to RUN at 00:00:00.
- Tick detection: sec_in is registered once. tick = sec_in & ~sec_q, a single-cycle pulse.
- Debounce, per button:
  - A counter increments while the raw input differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A press pulse is the one-cycle rising edge of the debounced level.
  - Latency from the raw stable level to the press pulse is DEBOUNCE_CYCLES+1 clk cycles.
- FSM transitions on mode press: RUN -> SET_HOUR -> SET_MIN -> RUN. An illegal state code (11) goes to RUN on the next cycle.
- RUN:
  - On tick, seconds advance in BCD with a full carry chain: s 59->00 carries into minutes, m 59->00 carries into hours, 23:59:59 -> 00:00:00.
  - btn_up is ignored.
- SET_HOUR: time is frozen and ticks are dropped. An up press increments hours 00..23 and wraps 23->00. No carry to or from other fields.
- SET_MIN: time is frozen. An up press increments minutes 00..59 and wraps 59->00. Hours are untouched.
- Leaving SET_MIN for RUN: seconds clear to 00 in that same cycle.
- Simultaneous events:
  - Mode press and tick in the same cycle in RUN: the tick is applied, and the state becomes SET_HOUR next cycle.
  - Mode press and up press in the same cycle in a set state: the increment applies to the current field first, then the state advances.
- Invariant: all digit registers update only on clk and always hold legal BCD (tens of seconds and minutes <= 5; hours <= 23).
- Digit outputs are registered, with zero combinational path from inputs.

Optional Feature:
- Macro: CLOCK_BLINK_EN.
- When defined:
  - Adds output blank (6 bits, bit i for digit(i+1)), reset 0.
  - A blink flag toggles on every sec_in edge, rising and falling.
  - In SET_HOUR, blank[5:4] = blink flag. In SET_MIN, blank[3:2] = blink flag. All other bits are 0.
  - In RUN, blank = 0.
  - An up press forces the blink flag to 0, so the edited field is visible immediately.
- When undefined: no blank port and no blink logic; the remaining behaviour is identical.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4: assert rst=0 mid-count -> digits immediately 0, set_mode=00. Release rst, apply 3 sec_in edges -> 00:00:03.
- Carry chain: in SET_HOUR load 23, in SET_MIN load 59, return to RUN (s=00), apply 59 ticks then 1 tick -> 23:59:59 then 00:00:00.
- Bounce: toggle btn_up 3 times with 2-cycle gaps, then hold 10 cycles in SET_MIN at m=07 -> exactly one increment, m=08, appearing DEBOUNCE_CYCLES+1 cycles after the level settles.
- Field wrap: SET_HOUR at 23 plus 1 up -> 00 with minutes unchanged. SET_MIN at 59 plus 1 up -> 00 with hours unchanged.
- Frozen time: in SET_HOUR apply 5 ticks -> digits unchanged. Mode press and tick in the same cycle in RUN at 00:00:09 -> 00:00:10 and set_mode=01.
- With CLOCK_BLINK_EN: in SET_MIN, blank[3:2] alternates on each sec_in edge; an up press forces blank[3:2]=00; in RUN, blank=0.
